// File: rtl/rf_pkg.sv
// Shared types for the register-file write-back path.
// Optional feature macro: WB_ROUND_ROBIN_EN (see rf_wb_arbiter).
package rf_pkg;

   localparam int REG_W    = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;

   // `reg` is a keyword, so the destination field is `dst`
   typedef struct packed {
      logic [REG_W-1:0]  dst;
      logic [DATA_W-1:0] data;
   } wb_req_t;

   typedef enum logic {
      WB_ALU  = 1'b0,
      WB_LOAD = 1'b1
   } wb_src_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus: two producer handshakes plus the register-file
// write port and pending mask. Producers use master, arbiter slave.
interface rf_wb_arbiter_if #(
   parameter int REG_W  = 5,
   parameter int DATA_W = 32
);

   logic              req0_valid;
   logic              req0_ready;
   logic [REG_W-1:0]  req0_reg;
   logic [DATA_W-1:0] req0_data;
   logic              req1_valid;
   logic              req1_ready;
   logic [REG_W-1:0]  req1_reg;
   logic [DATA_W-1:0] req1_data;
   logic [REG_W-1:0]  write_reg;
   logic [DATA_W-1:0] write_data;
   logic              regWrite;
   logic              grant_id;
   logic [31:0]       pending;

   modport master (
      output req0_valid, req0_reg, req0_data,
      output req1_valid, req1_reg, req1_data,
      input  req0_ready, req1_ready,
      input  write_reg, write_data, regWrite,
      input  grant_id, pending
   );

   modport slave (
      input  req0_valid, req0_reg, req0_data,
      input  req1_valid, req1_reg, req1_data,
      output req0_ready, req1_ready,
      output write_reg, write_data, regWrite,
      output grant_id, pending
   );

endinterface

// File: rtl/wb_slot.sv
// One-entry write-back holding slot. A load to register 0 is
// swallowed: the slot ends empty so no write is ever issued.
module wb_slot
   import rf_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    load,
   input  logic    drain,
   input  wb_req_t in_req,
   output logic    full,
   output wb_req_t req
);

   logic    full_q, full_d;
   wb_req_t req_q, req_d;

   always_comb begin
      full_d = full_q;
      req_d  = req_q;
      if (drain)
         full_d = 1'b0;
      // load after drain so a same-edge refill wins
      if (load) begin
         full_d = (in_req.dst != '0);
         req_d  = in_req;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         req_q  <= '0;
      end else begin
         full_q <= full_d;
         req_q  <= req_d;
      end
   end

   assign full = full_q;
   assign req  = req_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-slot write-back arbiter for the register-file write port.
// Define WB_ROUND_ROBIN_EN for alternating different-reg contention.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int REG_W  = rf_pkg::REG_W,
   parameter int DATA_W = rf_pkg::DATA_W
) (
   input logic             clk,
   input logic             rst_n,
   rf_wb_arbiter_if.slave  bus
);

   wb_req_t in0, in1, s0, s1;
   logic    full0, full1;
   logic    gnt_vld, gnt0, gnt1;
   logic    ld0, ld1;
   wb_src_t gsel, pol;
   logic    older_vld_q, older_vld_d;
   wb_src_t older_id_q, older_id_d;

   assign in0 = '{dst: bus.req0_reg, data: bus.req0_data};
   assign in1 = '{dst: bus.req1_reg, data: bus.req1_data};

`ifdef WB_ROUND_ROBIN_EN
   wb_src_t rr_q, rr_d;
   logic    use_pol;
   // rr_q holds the last policy winner; the other side goes next
   assign pol = (rr_q == WB_ALU) ? WB_LOAD : WB_ALU;
`else
   assign pol = WB_ALU;
`endif

   always_comb begin
      gnt_vld = full0 | full1;
      gsel    = WB_ALU;
`ifdef WB_ROUND_ROBIN_EN
      use_pol = 1'b0;
`endif
      unique case (1'b1)
         full0 && full1: begin
            if (s0.dst == s1.dst && older_vld_q)
               gsel = older_id_q;
            else begin
               gsel = pol;
`ifdef WB_ROUND_ROBIN_EN
               use_pol = 1'b1;
`endif
            end
         end
         full1 && !full0: gsel = WB_LOAD;
         default:         gsel = WB_ALU;
      endcase
   end

   assign gnt0 = gnt_vld && (gsel == WB_ALU);
   assign gnt1 = gnt_vld && (gsel == WB_LOAD);

   assign bus.req0_ready = !full0 || gnt0;
   assign bus.req1_ready = !full1 || gnt1;
   assign ld0 = bus.req0_valid && bus.req0_ready;
   assign ld1 = bus.req1_valid && bus.req1_ready;

   // a slot loading behind a full, non-draining peer is younger
   always_comb begin
      older_vld_d = older_vld_q && !gnt_vld;
      older_id_d  = older_id_q;
      if (ld0 && in0.dst != '0 && full1 && !gnt1) begin
         older_vld_d = 1'b1;
         older_id_d  = WB_LOAD;
      end
      if (ld1 && in1.dst != '0 && full0 && !gnt0) begin
         older_vld_d = 1'b1;
         older_id_d  = WB_ALU;
      end
   end

`ifdef WB_ROUND_ROBIN_EN
   assign rr_d = use_pol ? gsel : rr_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         older_vld_q <= 1'b0;
         older_id_q  <= WB_ALU;
`ifdef WB_ROUND_ROBIN_EN
         rr_q        <= WB_LOAD;
`endif
      end else begin
         older_vld_q <= older_vld_d;
         older_id_q  <= older_id_d;
`ifdef WB_ROUND_ROBIN_EN
         rr_q        <= rr_d;
`endif
      end
   end

   wb_slot u_slot0 (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (ld0),
      .drain  (gnt0),
      .in_req (in0),
      .full   (full0),
      .req    (s0)
   );

   wb_slot u_slot1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (ld1),
      .drain  (gnt1),
      .in_req (in1),
      .full   (full1),
      .req    (s1)
   );

   always_comb begin
      bus.pending = '0;
      if (full0)
         bus.pending[s0.dst] = 1'b1;
      if (full1)
         bus.pending[s1.dst] = 1'b1;
      bus.pending[0] = 1'b0;
   end

   assign bus.regWrite   = gnt_vld;
   assign bus.grant_id   = gnt_vld ? gsel : 1'b0;
   assign bus.write_reg  = gnt0 ? s0.dst
                         : gnt1 ? s1.dst : '0;
   assign bus.write_data = gnt0 ? s0.data
                         : gnt1 ? s1.data : '0;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed plus random bench for rf_wb_arbiter, checked every
// cycle against an age-stamped two-slot reference model.
module tb_rf_wb_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   rf_wb_arbiter_if bus ();

   rf_wb_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // model: slots carry the cycle they were loaded in
   bit          m_full  [2];
   logic [4:0]  m_dst   [2];
   logic [31:0] m_data  [2];
   int          m_stamp [2];
   int          m_last;
   int          cyc;
   logic [31:0] m_rf   [32];
   logic [31:0] dut_rf [32];

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) m_full[i] = 0;
      m_last = 1;
   endtask

   task automatic reset_cycle();
      rst_n = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step(input bit v0,
                       input logic [4:0] r0,
                       input logic [31:0] d0,
                       input bit v1,
                       input logic [4:0] r1,
                       input logic [31:0] d1);
      bit          g_vld, pol;
      int          g;
      logic [31:0] pend;
      bit          rdy [2];
      bit          vv  [2];
      logic [4:0]  rr  [2];
      logic [31:0] dd  [2];
      g_vld = m_full[0] || m_full[1];
      g = m_full[0] ? 0 : 1;
      pol = 0;
      if (m_full[0] && m_full[1]) begin
         if (m_dst[0] == m_dst[1] &&
             m_stamp[0] != m_stamp[1])
            g = (m_stamp[0] < m_stamp[1]) ? 0 : 1;
         else begin
            pol = 1;
`ifdef WB_ROUND_ROBIN_EN
            g = 1 - m_last;
`else
            g = 0;
`endif
         end
      end
      pend = '0;
      for (int i = 0; i < 2; i++)
         if (m_full[i]) pend[m_dst[i]] = 1'b1;
      for (int i = 0; i < 2; i++)
         rdy[i] = !m_full[i] || (g_vld && g == i);
      chk("regWrite", 32'(bus.regWrite), 32'(g_vld));
      chk("write_reg", 32'(bus.write_reg),
          g_vld ? 32'(m_dst[g]) : 32'd0);
      chk("write_data", bus.write_data,
          g_vld ? m_data[g] : 32'd0);
      chk("grant_id", 32'(bus.grant_id),
          g_vld ? 32'(g) : 32'd0);
      chk("pending", bus.pending, pend);
      chk("req0_ready", 32'(bus.req0_ready), 32'(rdy[0]));
      chk("req1_ready", 32'(bus.req1_ready), 32'(rdy[1]));
      if (bus.regWrite === 1'b1)
         dut_rf[bus.write_reg] = bus.write_data;
      bus.req0_valid = v0;
      bus.req0_reg   = r0;
      bus.req0_data  = d0;
      bus.req1_valid = v1;
      bus.req1_reg   = r1;
      bus.req1_data  = d1;
      vv[0] = v0; rr[0] = r0; dd[0] = d0;
      vv[1] = v1; rr[1] = r1; dd[1] = d1;
      if (g_vld) begin
         m_rf[m_dst[g]] = m_data[g];
         m_full[g] = 0;
      end
      if (pol) m_last = g;
      for (int i = 0; i < 2; i++)
         if (vv[i] && rdy[i]) begin
            m_full[i] = 0;
            if (rr[i] != 0) begin
               m_full[i]  = 1;
               m_dst[i]   = rr[i];
               m_data[i]  = dd[i];
               m_stamp[i] = cyc;
            end
         end
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         m_rf[i]   = '0;
         dut_rf[i] = '0;
      end
      cyc = 0;
      bus.req0_valid = 1'b0;
      bus.req0_reg   = '0;
      bus.req0_data  = '0;
      bus.req1_valid = 1'b0;
      bus.req1_reg   = '0;
      bus.req1_data  = '0;
      reset_cycle();

      // single write to r5
      step(1, 5, 32'h1234, 0, 0, 0);
      chk("t1_we", 32'(bus.regWrite), 32'd1);
      chk("t1_reg", 32'(bus.write_reg), 32'd5);
      chk("t1_data", bus.write_data, 32'h1234);
      chk("t1_pend5", 32'(bus.pending[5]), 32'd1);
      idle(1);
      chk("t1_pend0", bus.pending, 32'd0);

      // different-reg contention
      for (int i = 0; i < 4; i++)
         step(1, 3, 32'hA, 1, 4, 32'hB);
      idle(4);

      // same-reg ordering, with slot 0 kept busy first
      step(1, 9, 32'h9, 0, 0, 0);
      step(1, 10, 32'h10, 1, 7, 32'h1);
      step(1, 7, 32'h2, 1, 7, 32'h1);
      step(1, 7, 32'h2, 0, 0, 0);
      idle(4);
      chk("t3_r7", dut_rf[7], 32'h2);

      // register 0 discard
      step(0, 0, 0, 1, 0, 32'hFFFF);
      idle(3);

      // streaming from requester 0
      for (int i = 1; i <= 8; i++)
         step(1, 5'(i), 32'(i * 3), 0, 0, 0);
      idle(2);

      // reset with both slots full
      step(1, 11, 32'h11, 1, 12, 32'h12);
      step(1, 13, 32'h13, 1, 14, 32'h14);
      reset_cycle();
      idle(2);

      // random traffic, small reg range for collisions
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 59) == 0)
            reset_cycle();
         else
            step($urandom_range(0, 2) != 0,
                 5'($urandom_range(0, 6)), $urandom,
                 $urandom_range(0, 2) != 0,
                 5'($urandom_range(0, 6)), $urandom);
      end
      idle(4);
      for (int i = 1; i < 16; i++)
         chk("rf_final", dut_rf[i], m_rf[i]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want done");
      $fatal(1, "timeout");
   end

endmodule
